// File: rtl/fetch_prefetch_unit.sv
// Decoupled instruction-fetch front end: sequences PCs, issues pipelined fetches over
// req/gnt/rvalid, buffers {instr, pc} in a FIFO for decode and handles redirects.
module fetch_prefetch_unit #(
  parameter logic [63:0] RESET_PC        = 64'h0000_0000_0000_0000,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        instr_mem_req_o,
  output logic [63:0] instr_mem_addr_o,
  input  logic        instr_mem_gnt_i,
  input  logic        instr_mem_rvalid_i,
  input  logic [31:0] instr_mem_rdata_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [63:0] fetch_pc_o,
  input  logic        fetch_ready_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic          run_q;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;

  logic [31:0]   buf_instr_q [DEPTH];
  logic [63:0]   buf_pc_q    [DEPTH];
  logic [63:0]   pq_pc_q     [DEPTH];

  logic          gnt_fire;
  logic          push;
  logic          pop;
  logic [31:0]   reserved;
  logic          unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc_i[1:0];

  // Every granted request already owns a FIFO slot unless it is going to be discarded,
  // so the buffer can never overflow when responses land.
  assign reserved = 32'(occ_q) + 32'(outstanding_q) - 32'(discard_q);

  // Memory side: a request transfers when req & gnt. Decode side: the head transfers when
  // fetch_valid_o & fetch_ready_i. Neither valid depends combinationally on its ready.
  assign instr_mem_req_o  = run_q & ~redirect_i
                          & (32'(outstanding_q) < MAX_OUTSTANDING)
                          & (reserved < DEPTH);
  assign instr_mem_addr_o = fetch_pc_q;

  assign gnt_fire = instr_mem_req_o & instr_mem_gnt_i;
  assign push     = instr_mem_rvalid_i & (discard_q == '0) & ~redirect_i;
  assign fetch_valid_o = (occ_q != '0);
  assign pop      = fetch_valid_o & fetch_ready_i & ~redirect_i;

  assign fetch_instr_o = fetch_valid_o ? buf_instr_q[rd_ptr_q] : 32'h0;
  assign fetch_pc_o    = fetch_valid_o ? buf_pc_q[rd_ptr_q]    : 64'h0;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(instr_mem_rvalid_i);
    discard_d     = discard_q;
    occ_d         = occ_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    pq_rd_d       = pq_rd_q;
    pq_wr_d       = pq_wr_q;

    if (redirect_i) begin
      // Everything still in flight belongs to the old stream.
      fetch_pc_d = {redirect_pc_i[63:2], 2'b00};
      discard_d  = outstanding_q - CW'(instr_mem_rvalid_i);
      occ_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      pq_rd_d    = '0;
      pq_wr_d    = '0;
    end else begin
      if (gnt_fire) begin
        fetch_pc_d = fetch_pc_q + 64'd4;
        pq_wr_d    = pq_wr_q + PW'(1);
      end
      if (instr_mem_rvalid_i) begin
        if (discard_q != '0) discard_d = discard_q - CW'(1);
        else                 pq_rd_d   = pq_rd_q + PW'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      occ_d = occ_q + OW'(push) - OW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q         <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      occ_q         <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      pq_rd_q       <= '0;
      pq_wr_q       <= '0;
    end else begin
      run_q         <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      occ_q         <= occ_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      pq_rd_q       <= pq_rd_d;
      pq_wr_q       <= pq_wr_d;
    end
  end

  // Storage arrays carry no reset; occupancy and pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= instr_mem_rdata_i;
      buf_pc_q[wr_ptr_q]    <= pq_pc_q[pq_rd_q];
    end
    if (gnt_fire) begin
      pq_pc_q[pq_wr_q] <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: linear cycle-by-cycle steps with hand-computed
// expectations, an in-order memory responder with programmable latency.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic [63:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redirect;
  logic [63:0] rpc;
  logic        valid;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        ready;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int lat         = 1;

  logic [63:0] rq_addr[$];
  int          rq_due[$];

  fetch_prefetch_unit #(
    .RESET_PC        (64'h0),
    .DEPTH           (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .instr_mem_req_o    (req),
    .instr_mem_addr_o   (addr),
    .instr_mem_gnt_i    (gnt),
    .instr_mem_rvalid_i (rvalid),
    .instr_mem_rdata_i  (rdata),
    .redirect_i         (redirect),
    .redirect_pc_i      (rpc),
    .fetch_valid_o      (valid),
    .fetch_instr_o      (instr),
    .fetch_pc_o         (pc),
    .fetch_ready_i      (ready)
  );

  always #5 clk = ~clk;

  // Memory image: instruction word at address a is 0xC0DE0000 ^ a[31:0].
  function automatic logic [31:0] mk(input logic [63:0] a);
    return 32'hC0DE_0000 ^ a[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample the request handshake before the edge, then drive the responder.
  task automatic tick();
    logic        fire;
    logic [63:0] a;
    #1;
    fire = req & gnt;
    a    = addr;
    @(posedge clk);
    cyc++;
    #1;
    if (fire) begin
      rq_addr.push_back(a);
      rq_due.push_back(cyc + lat - 1);
    end
    if (rq_addr.size() != 0 && rq_due[0] <= cyc) begin
      rvalid = 1'b1;
      rdata  = mk(rq_addr.pop_front());
      void'(rq_due.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = 32'h0;
    end
    #1;
  endtask

  initial begin
    reset_n = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    redirect = 1'b0; rpc = 64'h0; ready = 1'b0;
    #12;
    chk("rst_req",   {63'd0, req},   64'd0);
    chk("rst_addr",  addr,           64'h0);
    chk("rst_valid", {63'd0, valid}, 64'd0);
    chk("rst_instr", {32'd0, instr}, 64'h0);
    chk("rst_pc",    pc,             64'h0);

    // Streaming: immediate gnt, rvalid one cycle later, decode always ready.
    reset_n = 1'b1; gnt = 1'b1; ready = 1'b1; lat = 1;
    tick();
    chk("s_req_first", {63'd0, req},   64'd1);
    chk("s_addr0",     addr,           64'h0);
    chk("s_valid_c0",  {63'd0, valid}, 64'd0);
    tick();
    chk("s_addr4",     addr,           64'h4);
    chk("s_valid_c1",  {63'd0, valid}, 64'd0);
    tick();
    chk("s_valid_c2",  {63'd0, valid}, 64'd1);
    chk("s_pc0",       pc,             64'h0);
    chk("s_instr0",    {32'd0, instr}, 64'hC0DE_0000);
    chk("s_addr8",     addr,           64'h8);
    tick();
    chk("s_pc4",       pc,             64'h4);
    chk("s_instr4",    {32'd0, instr}, 64'hC0DE_0004);
    chk("s_addrC",     addr,           64'hC);
    tick();
    chk("s_pc8",       pc,             64'h8);
    chk("s_instr8",    {32'd0, instr}, 64'hC0DE_0008);

    // Decode stalls: buffer fills to DEPTH and requests stop.
    ready = 1'b0;
    tick(); tick();
    chk("f_req_off",   {63'd0, req},   64'd0);
    chk("f_addr_hold", addr,           64'h18);
    tick();
    chk("f_req_off2",  {63'd0, req},   64'd0);
    chk("f_head_pc",   pc,             64'h8);
    ready = 1'b1;
    tick();
    chk("f_pcC",       pc,             64'hC);
    chk("f_req_back",  {63'd0, req},   64'd1);
    chk("f_addr18",    addr,           64'h18);
    tick();
    chk("f_pc10",      pc,             64'h10);
    tick();
    chk("f_pc14",      pc,             64'h14);
    chk("f_instr14",   {32'd0, instr}, 64'hC0DE_0014);
    tick();
    chk("f_pc18",      pc,             64'h18);

    // Grant withheld: address must hold while req stays up.
    gnt = 1'b0;
    tick();
    chk("g_addr_1",    addr,           64'h24);
    chk("g_req_1",     {63'd0, req},   64'd1);
    chk("g_pc1C",      pc,             64'h1C);
    tick();
    chk("g_addr_2",    addr,           64'h24);
    chk("g_pc20",      pc,             64'h20);
    tick();
    chk("g_addr_3",    addr,           64'h24);
    chk("g_req_3",     {63'd0, req},   64'd1);
    chk("g_empty_v",   {63'd0, valid}, 64'd0);
    chk("g_empty_i",   {32'd0, instr}, 64'h0);
    chk("g_empty_pc",  pc,             64'h0);

    // Redirect to 0x10, then with 0x10/0x14 in flight redirect to 0x200.
    gnt = 1'b1; lat = 3; redirect = 1'b1; rpc = 64'h10; #1;
    chk("r1_req_off",  {63'd0, req},   64'd0);
    tick(); redirect = 1'b0; #1;
    chk("r1_addr10",   addr,           64'h10);
    chk("r1_req",      {63'd0, req},   64'd1);
    tick();
    chk("r1_addr14",   addr,           64'h14);
    tick();
    chk("r1_out_full", {63'd0, req},   64'd0);
    redirect = 1'b1; rpc = 64'h200; #1;
    tick(); redirect = 1'b0; #1;
    chk("r2_addr200",  addr,           64'h200);
    chk("r2_req_wait", {63'd0, req},   64'd0);
    chk("r2_valid_a",  {63'd0, valid}, 64'd0);
    tick();
    chk("r2_valid_b",  {63'd0, valid}, 64'd0);
    chk("r2_req",      {63'd0, req},   64'd1);
    chk("r2_addr200b", addr,           64'h200);
    tick();
    chk("r2_valid_c",  {63'd0, valid}, 64'd0);
    chk("r2_addr204",  addr,           64'h204);
    tick(); tick();
    chk("r2_valid_d",  {63'd0, valid}, 64'd0);
    tick();
    chk("r2_valid_e",  {63'd0, valid}, 64'd1);
    chk("r2_pc200",    pc,             64'h200);
    chk("r2_instr200", {32'd0, instr}, 64'hC0DE_0200);

    // Redirect colliding with rvalid and pop, one more stale request in flight; unaligned target.
    ready = 1'b0;
    tick(); tick(); tick();
    chk("r3_head",     pc,             64'h200);
    ready = 1'b1; redirect = 1'b1; rpc = 64'h1003; #1;
    chk("r3_req_off",  {63'd0, req},   64'd0);
    tick(); redirect = 1'b0; #1;
    chk("r3_flushed",  {63'd0, valid}, 64'd0);
    chk("r3_instr0",   {32'd0, instr}, 64'h0);
    chk("r3_pc0",      pc,             64'h0);
    chk("r3_addr1000", addr,           64'h1000);
    chk("r3_req",      {63'd0, req},   64'd1);
    tick();
    chk("r3_dropped",  {63'd0, valid}, 64'd0);
    tick(); tick(); tick();
    chk("r3_valid",    {63'd0, valid}, 64'd1);
    chk("r3_pc1000",   pc,             64'h1000);
    chk("r3_instr",    {32'd0, instr}, 64'hC0DE_1000);

    // Asynchronous reset mid-stream, then restart from RESET_PC.
    reset_n = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    rq_addr.delete(); rq_due.delete(); lat = 1; #1;
    chk("ar_req",      {63'd0, req},   64'd0);
    chk("ar_valid",    {63'd0, valid}, 64'd0);
    chk("ar_addr",     addr,           64'h0);
    chk("ar_pc",       pc,             64'h0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("ar_req_up",   {63'd0, req},   64'd1);
    chk("ar_addr0",    addr,           64'h0);
    tick();
    chk("ar_addr4",    addr,           64'h4);
    chk("ar_valid0",   {63'd0, valid}, 64'd0);
    tick();
    chk("ar_valid1",   {63'd0, valid}, 64'd1);
    chk("ar_pc0",      pc,             64'h0);
    chk("ar_instr0",   {32'd0, instr}, 64'hC0DE_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
